// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state codes and frame header.
package loader_pkg;

    localparam logic [7:0] DEF_HEADER = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CHK  = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/word_packer.sv
// Packs MSB-first bytes into NBITS-wide words; word_valid is combinational
// on the final byte so the loader can register the write one cycle later.
module word_packer #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic [NBITS-1:0] o_word,
    output logic             o_word_valid
);

    logic [1:0]       cnt;
    logic [NBITS-9:0] shift;

    assign o_word       = {shift, i_byte};
    assign o_word_valid = i_valid && (cnt == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt   <= 2'd0;
            shift <= '0;
        end else if (i_valid) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[NBITS-17:0], i_byte};
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Frames a UART byte stream into a program image and writes instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader
    import loader_pkg::*;
#(
    parameter int         NBITS     = 32,
    parameter int         ADDR_BITS = 10,
    parameter logic [7:0] HEADER    = DEF_HEADER
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_mem_we,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_data,
    output logic             o_cpu_reset,
    output logic             o_done,
    output logic             o_error
);

    state_t                 state;
    state_t                 state_n;
    logic [ADDR_BITS-1:0]   idx;
    logic [7:0]             len_q;
    logic [NBITS-1:0]       word;
    logic                   word_valid;
    logic                   word_last;
    logic                   len_bad;
    logic                   in_len;
    logic                   in_data;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             chk_q;
`endif

    assign in_len  = i_rx_valid && (state == ST_LEN);
    assign in_data = i_rx_valid && (state == ST_DATA);

    // Compare at 32 bits so the bound works for any ADDR_BITS.
    assign len_bad = (i_rx_data == 8'd0) ||
                     ({24'd0, i_rx_data} > (32'd1 << ADDR_BITS));

    assign word_last = (({{(32-ADDR_BITS){1'b0}}, idx} + 32'd1) ==
                        {24'd0, len_q});

    word_packer #(.NBITS(NBITS)) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (in_len),
        .i_valid      (in_data),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_comb begin
        state_n = state;
        if (i_rx_valid) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_rx_data == HEADER) state_n = ST_LEN;
                end
                ST_LEN: state_n = len_bad ? ST_ERR : ST_DATA;
                ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (word_valid && word_last) state_n = ST_CHK;
`else
                    if (word_valid && word_last) state_n = ST_DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: state_n = (i_rx_data == chk_q) ? ST_DONE : ST_ERR;
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            len_q       <= 8'd0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_cpu_reset <= 1'b1;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_n;
            o_mem_we    <= word_valid;
            o_cpu_reset <= (state_n != ST_DONE);
            o_done      <= (state_n == ST_DONE);
            o_error     <= (state_n == ST_ERR);
            if (in_len) begin
                idx   <= '0;
                len_q <= i_rx_data;
            end else if (word_valid) begin
                idx        <= idx + 1'b1;
                o_mem_addr <= {{(NBITS-ADDR_BITS-2){1'b0}}, idx, 2'b00};
                o_mem_data <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset || in_len) chk_q <= 8'd0;
        else if (in_data)      chk_q <= chk_q ^ i_rx_data;
    end
`endif

endmodule
